// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: opcodes, condition-code encodings, HALT trap vector
// and the writeback-stage run/halt state type.
package lc3_pkg;

  localparam int unsigned XLEN_DEF = 16;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [7:0] DEF_HALT_VECTOR = 8'h25;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  localparam logic [2:0] R7 = 3'd7;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALT   = 2'd1,
    HALTED = 2'd2
  } wb_state_t;

endpackage

// File: rtl/lc3_wb_decode.sv
// Architectural-effect decode of an LC-3 instruction word: register write,
// condition-code update, destination register and HALT detection.
module lc3_wb_decode
  import lc3_pkg::*;
#(
  parameter logic [7:0] HALT_VECTOR = DEF_HALT_VECTOR
) (
  input  logic [15:0] ir,
  output logic        writes,
  output logic        sets_cc,
  output logic [2:0]  dr,
  output logic        is_halt
);

  logic [3:0] op;
  logic       unused_ir_bit8;

  assign op             = ir[15:12];
  assign unused_ir_bit8 = ir[8];

  always_comb begin
    writes  = 1'b0;
    sets_cc = 1'b0;
    dr      = ir[11:9];
    is_halt = 1'b0;
    case (op)
      OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDI, OP_LDR, OP_LEA: begin
        writes  = 1'b1;
        sets_cc = 1'b1;
      end
      // Subroutine calls and traps link the return address into R7.
      OP_JSR: begin
        writes = 1'b1;
        dr     = R7;
      end
      OP_TRAP: begin
        writes  = 1'b1;
        dr      = R7;
        is_halt = (ir[7:0] == HALT_VECTOR);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lc3_writeback_stage.sv
// LC-3 writeback stage: W pipeline register, commit decode, NZP flags and the
// halt state machine. Define LC3_WB_TRACE_EN for a per-commit simulation trace.
module lc3_writeback_stage
  import lc3_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_DEF,
  parameter logic [7:0]  HALT_VECTOR = DEF_HALT_VECTOR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            M_v,
  input  logic [XLEN-1:0] M_pc,
  input  logic [XLEN-1:0] M_ir,
  input  logic [XLEN-1:0] M_result,
  input  logic            stall,
  output logic            W_v,
  output logic [XLEN-1:0] W_pc,
  output logic [XLEN-1:0] W_ir,
  output logic            regWE,
  output logic [2:0]      regDR,
  output logic [XLEN-1:0] regData,
  output logic [2:0]      cc,
  output logic            isHalt,
  output logic            halted
);

  wb_state_t       state, state_nxt;
  logic            W_valid_r;
  logic [XLEN-1:0] W_pc_r, W_ir_r, W_res_r;

  logic            dec_writes, dec_sets_cc, dec_is_halt;
  logic [2:0]      dec_dr;
  logic            commit;
  logic [2:0]      cc_nxt;

  lc3_wb_decode #(
    .HALT_VECTOR(HALT_VECTOR)
  ) u_decode (
    .ir      (W_ir_r[15:0]),
    .writes  (dec_writes),
    .sets_cc (dec_sets_cc),
    .dr      (dec_dr),
    .is_halt (dec_is_halt)
  );

  // W pipeline register; once halting starts nothing new becomes valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      W_valid_r <= 1'b0;
      W_pc_r    <= '0;
      W_ir_r    <= '0;
      W_res_r   <= '0;
    end else if (!stall) begin
      if (state != RUN) begin
        W_valid_r <= 1'b0;
      end else begin
        W_valid_r <= M_v;
        W_pc_r    <= M_pc;
        W_ir_r    <= M_ir;
        W_res_r   <= M_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cc    <= CC_Z;
    end else begin
      state <= state_nxt;
      if (commit && dec_sets_cc) cc <= cc_nxt;
    end
  end

  // Commit qualification, halt sequencing and writeback outputs.
  always_comb begin
    state_nxt = state;
    commit    = W_valid_r && !stall && (state == RUN);
    W_v       = commit;
    regWE     = commit && dec_writes;
    isHalt    = commit && dec_is_halt;
    halted    = (state != RUN);
    regDR     = dec_dr;
    regData   = W_res_r;
    W_pc      = W_pc_r;
    W_ir      = W_ir_r;

    if (W_res_r[XLEN-1])       cc_nxt = CC_N;
    else if (W_res_r == '0)    cc_nxt = CC_Z;
    else                       cc_nxt = CC_P;

    case (state)
      RUN:     if (commit && dec_is_halt) state_nxt = HALT;
      HALT:    state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

`ifdef LC3_WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst_n && W_v) begin
      $write("W pc=%h ir=%h", W_pc, W_ir);
      if (regWE)  $write(" R%0d<=%h", regDR, regData);
      if (isHalt) $write(" HALT");
      $write("\n");
    end
  end
`endif

endmodule

// File: tb/tb_lc3_writeback_stage.sv
// Directed self-checking bench for lc3_writeback_stage.
module tb_lc3_writeback_stage;

  localparam int unsigned XLEN = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            M_v;
  logic [XLEN-1:0] M_pc, M_ir, M_result;
  logic            stall;
  logic            W_v;
  logic [XLEN-1:0] W_pc, W_ir;
  logic            regWE;
  logic [2:0]      regDR;
  logic [XLEN-1:0] regData;
  logic [2:0]      cc;
  logic            isHalt;
  logic            halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lc3_writeback_stage dut (
    .clk(clk), .rst_n(rst_n),
    .M_v(M_v), .M_pc(M_pc), .M_ir(M_ir), .M_result(M_result),
    .stall(stall),
    .W_v(W_v), .W_pc(W_pc), .W_ir(W_ir),
    .regWE(regWE), .regDR(regDR), .regData(regData),
    .cc(cc), .isHalt(isHalt), .halted(halted)
  );

  // Advance past the next rising edge; inputs are driven here, outputs sampled #1 later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_m(input logic v, input logic [15:0] pc, input logic [15:0] ir,
                         input logic [15:0] res);
    M_v = v; M_pc = pc; M_ir = ir; M_result = res;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0;
    drive_m(1'b0, 16'h0, 16'h0, 16'h0);
    #13;
    checks++; if (W_v !== 1'b0) begin errors++; $display("FAIL reset_wv got=%b exp=0", W_v); end
    checks++; if (cc !== 3'b010) begin errors++; $display("FAIL reset_cc got=%b exp=010", cc); end
    checks++; if (W_ir !== 16'h0) begin errors++; $display("FAIL reset_wir got=%h exp=0000", W_ir); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      checks++;
      if (W_v !== 1'b0 || regWE !== 1'b0 || cc !== 3'b010 || halted !== 1'b0 || isHalt !== 1'b0) begin
        errors++;
        $display("FAIL idle_cycle%0d got wv=%b we=%b cc=%b halted=%b ishalt=%b exp 0 0 010 0 0",
                 i, W_v, regWE, cc, halted, isHalt);
      end
    end
  endtask

  task automatic test_alu_cc();
    // ADD R1,R1,#1 producing 8000: write R1, flags go negative next cycle
    drive_m(1'b1, 16'h3000, 16'h1261, 16'h8000);
    tick(); drive_m(1'b0, 16'h0, 16'h0, 16'h0); #1;
    checks++;
    if (W_v !== 1'b1 || regWE !== 1'b1 || regDR !== 3'd1 || regData !== 16'h8000) begin
      errors++;
      $display("FAIL add_commit got wv=%b we=%b dr=%0d data=%h exp 1 1 1 8000", W_v, regWE, regDR, regData);
    end
    checks++; if (W_pc !== 16'h3000 || W_ir !== 16'h1261) begin
      errors++; $display("FAIL add_pc_ir got pc=%h ir=%h exp 3000 1261", W_pc, W_ir); end
    checks++; if (cc !== 3'b010) begin errors++; $display("FAIL add_cc_same_cycle got=%b exp=010", cc); end
    tick(); #1;
    checks++; if (cc !== 3'b100) begin errors++; $display("FAIL add_cc_next got=%b exp=100", cc); end
    checks++; if (W_v !== 1'b0) begin errors++; $display("FAIL bubble_wv got=%b exp=0", W_v); end

    // AND R0 producing zero, then ADD producing positive, back to back
    drive_m(1'b1, 16'h3001, 16'h5020, 16'h0000);
    tick(); drive_m(1'b1, 16'h3002, 16'h1265, 16'h0005); #1;
    checks++; if (regWE !== 1'b1 || regDR !== 3'd0) begin
      errors++; $display("FAIL and_commit got we=%b dr=%0d exp 1 0", regWE, regDR); end
    tick(); drive_m(1'b1, 16'h3003, 16'h0E02, 16'h1234); #1;
    checks++; if (cc !== 3'b010) begin errors++; $display("FAIL and_cc got=%b exp=010", cc); end
    checks++; if (regWE !== 1'b1 || regDR !== 3'd1 || regData !== 16'h0005) begin
      errors++; $display("FAIL add_pos_commit got we=%b dr=%0d data=%h exp 1 1 0005", regWE, regDR, regData); end
    // BR commits without a register write
    tick(); drive_m(1'b0, 16'h0, 16'h0, 16'h0); #1;
    checks++; if (cc !== 3'b001) begin errors++; $display("FAIL add_pos_cc got=%b exp=001", cc); end
    checks++; if (W_v !== 1'b1 || regWE !== 1'b0) begin
      errors++; $display("FAIL br_nowrite got wv=%b we=%b exp 1 0", W_v, regWE); end
    tick(); #1;
    checks++; if (cc !== 3'b001) begin errors++; $display("FAIL br_cc got=%b exp=001", cc); end
  endtask

  task automatic test_jsr();
    drive_m(1'b1, 16'h3004, 16'h4802, 16'h3005);
    tick(); drive_m(1'b0, 16'h0, 16'h0, 16'h0); #1;
    checks++;
    if (W_v !== 1'b1 || regWE !== 1'b1 || regDR !== 3'd7 || regData !== 16'h3005) begin
      errors++;
      $display("FAIL jsr_commit got wv=%b we=%b dr=%0d data=%h exp 1 1 7 3005", W_v, regWE, regDR, regData);
    end
    tick(); #1;
    checks++; if (cc !== 3'b001) begin errors++; $display("FAIL jsr_cc got=%b exp=001", cc); end
  endtask

  task automatic test_halt_stall();
    drive_m(1'b1, 16'h300F, 16'hF025, 16'h3010);
    tick();
    drive_m(1'b1, 16'h3010, 16'h1261, 16'h7777);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (W_v !== 1'b0 || isHalt !== 1'b0 || W_ir !== 16'hF025 || halted !== 1'b0) begin
        errors++;
        $display("FAIL halt_stall%0d got wv=%b ishalt=%b ir=%h halted=%b exp 0 0 f025 0",
                 i, W_v, isHalt, W_ir, halted);
      end
      tick();
    end
    stall = 1'b0; #1;
    checks++;
    if (W_v !== 1'b1 || isHalt !== 1'b1 || regWE !== 1'b1 || regDR !== 3'd7 || regData !== 16'h3010) begin
      errors++;
      $display("FAIL halt_commit got wv=%b ishalt=%b we=%b dr=%0d data=%h exp 1 1 1 7 3010",
               W_v, isHalt, regWE, regDR, regData);
    end
    tick(); #1;
    checks++;
    if (W_v !== 1'b0 || isHalt !== 1'b0 || halted !== 1'b1 || regWE !== 1'b0) begin
      errors++;
      $display("FAIL halt_after got wv=%b ishalt=%b halted=%b we=%b exp 0 0 1 0", W_v, isHalt, halted, regWE);
    end
  endtask

  task automatic test_halted();
    for (int i = 0; i < 10; i++) begin
      drive_m(1'b1, 16'(16'h3020 + i), 16'h1261, 16'h8000);
      tick(); #1;
      checks++;
      if (W_v !== 1'b0 || regWE !== 1'b0 || isHalt !== 1'b0 || halted !== 1'b1 || cc !== 3'b001) begin
        errors++;
        $display("FAIL halted_cycle%0d got wv=%b we=%b ishalt=%b halted=%b cc=%b exp 0 0 0 1 001",
                 i, W_v, regWE, isHalt, halted, cc);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_m(1'b0, 16'h0, 16'h0, 16'h0);
    rst_n = 1'b0; #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_unhalt got=%b exp=0", halted); end
    rst_n = 1'b1;
    drive_m(1'b1, 16'h3100, 16'h1261, 16'h8000);
    tick(); drive_m(1'b1, 16'h3101, 16'h5020, 16'h0007); #1;
    checks++; if (W_v !== 1'b1 || regWE !== 1'b1) begin
      errors++; $display("FAIL rerun_add got wv=%b we=%b exp 1 1", W_v, regWE); end
    tick(); drive_m(1'b0, 16'h0, 16'h0, 16'h0); #1;
    checks++; if (cc !== 3'b100 || W_v !== 1'b1 || W_ir !== 16'h5020) begin
      errors++; $display("FAIL pre_reset got cc=%b wv=%b ir=%h exp 100 1 5020", cc, W_v, W_ir); end
    rst_n = 1'b0; #1;
    checks++;
    if (W_v !== 1'b0 || regWE !== 1'b0 || cc !== 3'b010 || halted !== 1'b0 || W_ir !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset got wv=%b we=%b cc=%b halted=%b ir=%h exp 0 0 010 0 0000",
               W_v, regWE, cc, halted, W_ir);
    end
    tick(); rst_n = 1'b1; #1;
    checks++; if (W_v !== 1'b0 || cc !== 3'b010) begin
      errors++; $display("FAIL post_reset got wv=%b cc=%b exp 0 010", W_v, cc); end
    drive_m(1'b1, 16'h3200, 16'h1265, 16'h0005);
    tick(); drive_m(1'b0, 16'h0, 16'h0, 16'h0); #1;
    checks++; if (W_v !== 1'b1 || regWE !== 1'b1 || regDR !== 3'd1 || regData !== 16'h0005) begin
      errors++; $display("FAIL resume_commit got wv=%b we=%b dr=%0d data=%h exp 1 1 1 0005",
                         W_v, regWE, regDR, regData); end
    tick(); #1;
    checks++; if (cc !== 3'b001) begin errors++; $display("FAIL resume_cc got=%b exp=001", cc); end
  endtask

  initial begin
    test_reset();
    test_alu_cc();
    test_jsr();
    test_halt_stall();
    test_halted();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_writeback_stage.md
Name: lc3_writeback_stage

Overview:
- Final (W) stage of the LC-3 pipeline.
- Registers the instruction leaving the memory stage and decodes its architectural effect: register-file write and NZP condition-code update.
- Detects the HALT trap and drives W_v / isHalt to the cycle/instruction counter directly downstream.
- Owns the halt state machine, so nothing retires after HALT.

Parameters:
XLEN, 16, datapath/PC/IR width
HALT_VECTOR, 8'h25, trapvect8 that identifies HALT

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
M_v  in  1  memory-stage slot holds a valid instruction
M_pc  in  XLEN  PC of that instruction
M_ir  in  XLEN  instruction word
M_result  in  XLEN  value to write back (ALU result, load data, or PC+1 link)
stall  in  1  hazard unit holds W this cycle
W_v  out  1  instruction commits this cycle (counter's W_v)
W_pc  out  XLEN  PC of W instruction
W_ir  out  XLEN  IR of W instruction
regWE  out  1  register-file write enable
regDR  out  3  destination register
regData  out  XLEN  write data
cc  out  3  NZP flags {N,Z,P}
isHalt  out  1  one-cycle pulse when HALT commits
halted  out  1  sticky: machine stopped

Behaviour:
- Reset (async, rst_n=0):
  - W_valid_r=0, W_pc_r=0, W_ir_r=0, W_res_r=0
  - cc=3'b010, state=RUN
  - All commit outputs are 0.
- Load on each posedge clk:
  - If stall=1: W registers hold.
  - Else if state≠RUN: W_valid_r<=0.
  - Else: W_valid_r<=M_v; pc/ir/result <= M_*.
- Commit:
  - commit = W_valid_r & ~stall & (state==RUN).
  - W_v = commit; outputs are combinational from the registers.
  - W_pc and W_ir are always driven from the registers.
- Decode by opcode ir[15:12]:
  - ADD 0001, AND 0101, NOT 1001, LD 0010, LDI 1010, LDR 0110, LEA 1110:
    - write DR=ir[11:9]
    - set cc from regData: N=bit15; Z=(value==0); P otherwise (exactly one bit set)
  - JSR/JSRR 0100 and TRAP 1111: write R7 with M_result; cc unchanged.
  - All other opcodes: no write, cc unchanged.
- regWE = commit & writes. regDR/regData are valid only while regWE=1.
- cc register updates at the posedge of a commit cycle; it is visible the next cycle.
- HALT = opcode 1111 & ir[7:0]==HALT_VECTOR.
- FSM:
  - RUN → HALT: on a commit of HALT.
    - R7 is still written that cycle.
    - isHalt = commit & HALT, combinational in the commit cycle.
  - HALT → HALTED: next cycle unconditionally.
    - isHalt=0; halted=1 from this cycle on.
  - HALTED: absorbing until reset.
    - W_v, regWE and isHalt are held 0 regardless of M_v.
- Stall during HALT in W: HALT does not commit until stall drops; isHalt fires exactly once.
- Reset mid-operation: immediate return to reset values; no partial commit.
- No wrap-around concerns. Equal XLEN widths; no arithmetic beyond the zero compare.

Optional Feature:
- Macro: LC3_WB_TRACE_EN.
- Defined: on every commit cycle, simulation prints one line: "W pc=%h ir=%h", plus " R%d<=%h" when regWE=1 and " HALT" when isHalt=1.
- Undefined: no display code is compiled. Ports and timing are identical either way.

Decomposition:
- Package lc3_pkg holds:
  - opcode constants (OP_ADD … OP_TRAP)
  - HALT_VECTOR default
  - CC encodings (CC_N=3'b100, CC_Z=3'b010, CC_P=3'b001)
  - FSM state enum (RUN, HALT, HALTED)
- One natural sub-module: lc3_wb_decode.
  - Combinational: ir → writes, sets_cc, dr, is_halt.
  - Reused by the hazard unit for scoreboard lookups.

Test Plan:
- Reset release, M_v=0 for 5 cycles → W_v=0, regWE=0, cc=010, halted=0 throughout.
- M: ir=16'h1261 (ADD R1,R1,#1), result=16'h8000 → next cycle W_v=1, regWE=1, regDR=1, regData=8000; following cycle cc=100.
- M: ir=16'h4802 (JSR), result=16'h3005 → regWE=1, regDR=7, regData=3005; cc unchanged from prior value.
- HALT ir=16'hF025 enters W with stall=1 for 3 cycles → W_v=0 and isHalt=0 during stall; on stall drop, isHalt=1 for exactly one cycle, R7 written; halted=1 thereafter.
- After halted, drive M_v=1 with ADD for 10 cycles → W_v=0 and regWE=0 every cycle; cc frozen.
- Assert rst_n=0 for one cycle mid-stream with valid W instruction (ir=16'h5020, AND) → commit outputs drop immediately; cc=010, state RUN; normal retire resumes on the next valid M_v.
